// File: rtl/dal_pkg.sv
// Shared constants and types for the DAL stage-4 early-exit selector.
// Lane geometry, index type and stage-4 FSM encoding.
package dal_pkg;

  localparam int PARA          = 16;
  localparam int PARALLEL_SIZE = 12;

  typedef logic [PARA-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } stage4_state_e;

endpackage

// File: rtl/exit_lane_tracker.sv
// One lane of stage 4: in-interval run counter, exit/forced flags and
// captured exit index. Exited lanes freeze until the record is consumed.
module exit_lane_tracker
  import dal_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      beat,
  input  logic      clear,
  input  logic      term,
  input  logic      flag,
  input  lane_idx_t pat,
  input  lane_idx_t j,
  output lane_idx_t cnt,
  output logic      exited,
  output logic      forced,
  output lane_idx_t idx,
  output logic      exit_now
);

  lane_idx_t cnt_nxt;
  logic      hit;

  // next run length and whether this beat crosses the patience threshold
  always_comb begin
    cnt_nxt = '0;
    if (!flag)
      cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
    hit      = !exited && (cnt_nxt >= pat);
    exit_now = exited || (beat && hit);
  end

  // lane state: count, exit capture, forced close on termination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      exited <= 1'b0;
      forced <= 1'b0;
      idx    <= '0;
    end else if (clear) begin
      cnt    <= '0;
      exited <= 1'b0;
      forced <= 1'b0;
    end else if (beat && !exited) begin
      cnt <= cnt_nxt;
      if (hit) begin
        exited <= 1'b1;
        idx    <= j;
      end else if (term) begin
        forced <= 1'b1;
        idx    <= j;
      end
    end
  end

endmodule

// File: rtl/pipe_stage4_exit_sel.sv
// Stage 4: per-lane patience-based early-exit selection with result record.
// DAL_STAGE4_STATS_EN adds res_beats_o, the accepted-beat count per record.
module pipe_stage4_exit_sel
  import dal_pkg::*;
(
  input  logic                          CLK_i,
  input  logic                          RST_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_last_i,
  input  logic [PARALLEL_SIZE-1:0]      out_of_mode_interval_i,
  input  logic [PARALLEL_SIZE*PARA-1:0] J_i,
  input  logic [PARA-1:0]               patience_i,
  output logic [PARALLEL_SIZE*PARA-1:0] interval_cnt_o,
`ifdef DAL_STAGE4_STATS_EN
  output logic [PARA-1:0]               res_beats_o,
`endif
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [PARALLEL_SIZE-1:0]      res_exit_mask_o,
  output logic [PARALLEL_SIZE-1:0]      res_forced_o,
  output logic [PARALLEL_SIZE*PARA-1:0] res_idx_o
);

  stage4_state_e state_q, state_d;
  lane_idx_t     pat_q, pat_in, pat_eff;
  logic          accept, term, clear;
  logic [PARALLEL_SIZE-1:0] exit_now;

  assign in_ready_o  = (state_q != REPORT);
  assign res_valid_o = (state_q == REPORT);
  assign accept      = in_valid_i && in_ready_o;
  assign clear       = res_valid_o && res_ready_i;
  assign term        = accept && (in_last_i || (&exit_now));

  // zero patience behaves as one; first beat uses the live value
  always_comb begin
    pat_in  = (patience_i == '0) ? lane_idx_t'(1) : patience_i;
    pat_eff = (state_q == IDLE) ? pat_in : pat_q;
  end

  // patience latched at the first beat of each sequence
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni)
      pat_q <= '0;
    else if (accept && state_q == IDLE)
      pat_q <= pat_in;
  end

  // FSM state register
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (term)
          state_d = REPORT;
        else if (accept)
          state_d = RUN;
      end
      REPORT: begin
        if (res_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar l = 0; l < PARALLEL_SIZE; l++) begin : g_lane
    exit_lane_tracker u_lane (
      .clk      (CLK_i),
      .rst_n    (RST_ni),
      .beat     (accept),
      .clear    (clear),
      .term     (term),
      .flag     (out_of_mode_interval_i[l]),
      .pat      (pat_eff),
      .j        (J_i[l*PARA +: PARA]),
      .cnt      (interval_cnt_o[l*PARA +: PARA]),
      .exited   (res_exit_mask_o[l]),
      .forced   (res_forced_o[l]),
      .idx      (res_idx_o[l*PARA +: PARA]),
      .exit_now (exit_now[l])
    );
  end

`ifdef DAL_STAGE4_STATS_EN
  lane_idx_t beats_q;

  // saturating count of beats accepted in the current sequence
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni)
      beats_q <= '0;
    else if (clear)
      beats_q <= '0;
    else if (accept && !(&beats_q))
      beats_q <= beats_q + 1'b1;
  end

  assign res_beats_o = beats_q;
`endif

endmodule

// File: tb/tb_pipe_stage4_exit_sel.sv
// Directed self-checking bench for pipe_stage4_exit_sel.
// Covers patience exit, counter reset, zero patience, stall, reset abort.
module tb_pipe_stage4_exit_sel;
  import dal_pkg::*;

  localparam int W = PARALLEL_SIZE*PARA;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_last = 0;
  logic [11:0]   flags = '1;
  logic [W-1:0]  j = '0;
  logic [15:0]   patience = '0;
  logic [W-1:0]  icnt;
  logic          res_valid;
  logic          res_ready = 0;
  logic [11:0]   res_mask;
  logic [11:0]   res_forced;
  logic [W-1:0]  res_idx;
`ifdef DAL_STAGE4_STATS_EN
  logic [15:0]   res_beats;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage4_exit_sel dut (
    .CLK_i                  (clk),
    .RST_ni                 (rst_n),
    .in_valid_i             (in_valid),
    .in_ready_o             (in_ready),
    .in_last_i              (in_last),
    .out_of_mode_interval_i (flags),
    .J_i                    (j),
    .patience_i             (patience),
    .interval_cnt_o         (icnt),
`ifdef DAL_STAGE4_STATS_EN
    .res_beats_o            (res_beats),
`endif
    .res_valid_o            (res_valid),
    .res_ready_i            (res_ready),
    .res_exit_mask_o        (res_mask),
    .res_forced_o           (res_forced),
    .res_idx_o              (res_idx)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane(input logic [W-1:0] v, input int l);
    return v[l*PARA +: PARA];
  endfunction

  // one accepted beat; outputs sampled 1ns after the edge
  task automatic beat(input logic [11:0] f, input logic [15:0] jv,
                      input logic last);
    flags    = f;
    j        = {12{jv}};
    in_last  = last;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic handshake();
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    #12;
    chk("rst_valid", W'(res_valid), W'(0));
    chk("rst_ready", W'(in_ready), W'(1));
    chk("rst_cnt", icnt, '0);
    chk("rst_mask", W'(res_mask), W'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // patience 3: lane 0 exits at J=7, others forced at J=9
    patience = 3;
    beat(12'hFFE, 16'd5, 0);
    beat(12'hFFE, 16'd6, 0);
    beat(12'hFFE, 16'd7, 0);
    chk("t1_valid_b3", W'(res_valid), W'(0));
    beat(12'hFFF, 16'd9, 1);
    chk("t1_valid", W'(res_valid), W'(1));
    chk("t1_mask", W'(res_mask), W'(12'h001));
    chk("t1_forced", W'(res_forced), W'(12'hFFE));
    chk("t1_idx0", W'(lane(res_idx, 0)), W'(7));
    chk("t1_idx1", W'(lane(res_idx, 1)), W'(9));
    chk("t1_idx11", W'(lane(res_idx, 11)), W'(9));
    handshake();
    chk("t1_done", W'(res_valid), W'(0));

    // patience 2: lane 2 run broken, exits on the last beat
    patience = 2;
    beat(12'hFFB, 16'd1, 0);
    chk("t2_cnt_b1", W'(lane(icnt, 2)), W'(1));
    beat(12'hFFF, 16'd2, 0);
    chk("t2_cnt_b2", W'(lane(icnt, 2)), W'(0));
    beat(12'hFFB, 16'd3, 0);
    chk("t2_cnt_b3", W'(lane(icnt, 2)), W'(1));
    beat(12'hFFB, 16'd4, 1);
    chk("t2_cnt_b4", W'(lane(icnt, 2)), W'(2));
    chk("t2_valid", W'(res_valid), W'(1));
    chk("t2_mask", W'(res_mask), W'(12'h004));
    chk("t2_forced", W'(res_forced), W'(12'hFFB));
    chk("t2_idx2", W'(lane(res_idx, 2)), W'(4));
    handshake();

    // patience 0 acts as 1: every lane exits on the first beat
    patience = 0;
    beat(12'h000, 16'd8, 0);
    chk("t3_valid", W'(res_valid), W'(1));
    chk("t3_mask", W'(res_mask), W'(12'hFFF));
    chk("t3_forced", W'(res_forced), W'(12'h000));
    chk("t3_idx5", W'(lane(res_idx, 5)), W'(8));

    // stall in REPORT with a pending beat
    flags = 12'h000;
    j = {12{16'd33}};
    patience = 3;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_ready", W'(in_ready), W'(0));
      chk("t4_mask", W'(res_mask), W'(12'hFFF));
      chk("t4_idx5", W'(lane(res_idx, 5)), W'(8));
      chk("t4_cnt0", W'(lane(icnt, 0)), W'(1));
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("t4_hs_cnt", W'(lane(icnt, 0)), W'(0));
    chk("t4_hs_ready", W'(in_ready), W'(1));
    chk("t4_hs_valid", W'(res_valid), W'(0));
    @(posedge clk); #1;
    in_valid = 0;
    chk("t4_next_cnt", W'(lane(icnt, 0)), W'(1));
    chk("t4_next_valid", W'(res_valid), W'(0));

    // reset mid-RUN discards the sequence
    rst_n = 0;
    #1;
    chk("t5_cnt", icnt, '0);
    chk("t5_valid", W'(res_valid), W'(0));
    chk("t5_ready", W'(in_ready), W'(1));
    chk("t5_mask", W'(res_mask), W'(0));
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_norec", W'(res_valid), W'(0));

`ifdef DAL_STAGE4_STATS_EN
    patience = 3;
    for (int i = 0; i < 7; i++)
      beat(12'hFFF, 16'(i), i == 6);
    chk("t6_valid", W'(res_valid), W'(1));
    chk("t6_beats", W'(res_beats), W'(7));
    handshake();
    chk("t6_clr", W'(res_beats), W'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage4_exit_sel.md
Name: pipe_stage4_exit_sel

Overview:
Downstream neighbour of the stage-3 interval comparator. Consumes per-lane out-of-interval flags and latched indices J for a sequence of beats. Tracks per-lane runs of consecutive in-interval beats against a patience threshold, and declares each lane's early-exit index. Returns the run counters to stage 3 as interval_cnt, and emits one result record per sequence over a valid/ready handshake.

Parameters:
PARA, 16, width of index, counter and patience fields
PARALLEL_SIZE, 12, number of lanes

Ports:
CLK_i  in  1  clock
RST_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  beat valid from stage 3
in_ready_o  out  1  stage 4 can accept a beat
in_last_i  in  1  final beat of the sequence
out_of_mode_interval_i  in  PARALLEL_SIZE  per-lane flag, 1 = score outside mode interval
J_i  in  PARALLEL_SIZE*PARA  per-lane index from stage 3
patience_i  in  PARA  consecutive in-interval beats required to exit
interval_cnt_o  out  PARALLEL_SIZE*PARA  per-lane run counter, fed back to stage 3
res_valid_o  out  1  result record valid
res_ready_i  in  1  consumer accepts the record
res_exit_mask_o  out  PARALLEL_SIZE  lane exited by patience
res_forced_o  out  PARALLEL_SIZE  lane closed by in_last_i without exiting
res_idx_o  out  PARALLEL_SIZE*PARA  per-lane exit index

Behaviour:
- Reset (async, RST_ni=0): state=IDLE. All counters, masks, indices, res_* = 0. in_ready_o=1. Deassertion is synchronous to CLK_i.
- FSM states are IDLE, RUN and REPORT.
- in_ready_o = (state != REPORT).
- A beat is accepted when in_valid_i & in_ready_o.
- IDLE, on accept:
  - Latch patience_i into pat_q. A value of 0 is treated as 1.
  - Process the beat using the lane rules below.
  - Go to RUN, or directly to REPORT if the termination condition is met.
- RUN, on accept:
  - Process the beat using the lane rules below.
  - pat_q is unchanged.
- Lane rules, applied only to lanes not yet exited:
  - Flag = 1: cnt <= 0.
  - Flag = 0: cnt <= cnt+1, saturating at 2^PARA-1.
  - If the new cnt >= pat_q, set exit_mask[lane] and capture idx[lane] <= J_i[lane] from that same beat.
  - Exited lanes freeze cnt and idx.
- Termination: all exit_mask bits set after the beat, OR in_last_i on the accepted beat. On termination:
  - Every lane not exited gets forced=1 and idx <= J_i of that final beat.
  - State -> REPORT.
- Simultaneous events: if a lane exits on the in_last_i beat, it counts as exited (mask=1, forced=0).
- REPORT:
  - res_valid_o=1. res_* hold stable until handshake.
  - On res_valid_o & res_ready_i: clear counters, masks and forced bits, then go to IDLE.
  - idx registers stay stale but are masked by the next sequence.
- Latency: res_valid_o asserts the cycle after the terminating beat is accepted.
- No beat is accepted in the handshake cycle.
- res_* are registered outputs. interval_cnt_o is the registered cnt.
- Invariant: exit_mask & forced == 0. In REPORT, exit_mask | forced = all ones.
- A reset asserted mid-sequence or during REPORT discards the record with no output.

Optional Feature:
DAL_STAGE4_STATS_EN
- Defined:
  - Adds output res_beats_o [PARA], the number of beats accepted in the sequence (first beat = 1), saturating.
  - It is valid alongside res_valid_o and cleared on handshake and on reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package dal_pkg holds:
  - PARA and PARALLEL_SIZE constants
  - typedef lane_idx_t (logic [PARA-1:0])
  - typedef enum stage4_state_e {IDLE, RUN, REPORT}
- Sub-module exit_lane_tracker, one instance per lane (generate loop), contains cnt, exit_mask, forced and idx registers.
- The top level holds the FSM, pat_q, the handshake and the optional stats counter.

Test Plan:
- patience=3, lane 0 flags 0,0,0 with J=5,6,7, others flag 1, in_last_i on beat 4 with J=9 -> lane 0 mask=1, idx=7; other lanes forced=1, idx=9; res_valid_o 1 cycle after beat 4.
- patience=2, lane 2 flags 0,1,0,0 with J=1..4 -> counter resets on beat 2; exit at beat 4 with idx=4; interval_cnt_o[2] sequence 1,0,1,2.
- patience=0, all flags 0 on the first beat, J=8 -> every lane exits (treated as patience 1), REPORT after beat 1, mask=FFF, forced=000.
- REPORT with res_ready_i held low 5 cycles, in_valid_i high -> in_ready_o=0, res_* stable; after handshake, next beat accepted in the following cycle with counters 0.
- Lane exits on the same beat as in_last_i -> mask=1, forced=0 for that lane.
- RST_ni pulsed low mid-RUN -> all outputs 0 immediately, state IDLE, no record emitted.
- With DAL_STAGE4_STATS_EN, a 7-beat sequence -> res_beats_o=7.
